// File: rtl/apple_placement_ctrl.sv
// apple_placement_ctrl
// Chooses a free, on-screen position for the snake-game apple in the VGA_clk domain.
// A candidate is taken from the free-running random generator and bounds-checked.
// It is then compared against every live body segment through a one-cycle-latency
// read of the body store. The result is published as apple_x/apple_y/apple_valid.
//
// Build option: define APPLE_SCORE_EN to add an 8-bit saturating "score" output.
// The score counts apples eaten and clears when the game (re)starts.

module apple_placement_ctrl #(
    parameter int GRID     = 10,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int LEN_W    = 5
) (
    input  logic             VGA_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             eat,
    input  logic [9:0]       random_x,
    input  logic [8:0]       random_y,
    input  logic [LEN_W:0]   snake_len,
    output logic [LEN_W-1:0] body_addr,
    input  logic [9:0]       body_x,
    input  logic [8:0]       body_y,
    output logic [9:0]       apple_x,
    output logic [8:0]       apple_y,
    output logic             apple_valid,
    output logic             busy
`ifdef APPLE_SCORE_EN
    ,
    output logic [7:0]       score
`endif
);

    // Largest legal top-left corner so the whole square stays visible.
    localparam logic [9:0]         X_MAX    = 10'(SCREEN_W - GRID);
    localparam logic [8:0]         Y_MAX    = 9'(SCREEN_H - GRID);
    localparam logic signed [10:0] GRID_S   = 11'(GRID);
    localparam logic signed [10:0] NEG_GRID = -GRID_S;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_SCAN   = 2'd2,
        ST_PLACE  = 2'd3
    } state_t;

    state_t           state;
    logic [9:0]       cand_x;
    logic [8:0]       cand_y;
    logic [LEN_W-1:0] cmp_idx;    // segment index whose data is on body_x/body_y now
    logic [LEN_W-1:0] scan_last;  // snake_len-1, frozen for the duration of a scan

    logic                cand_ok;
    logic signed [10:0]  dx;
    logic signed [10:0]  dy;
    logic                x_near;
    logic                y_near;
    logic                overlap;

    // Bounds check on the raw generator outputs (the values latched this cycle).
    assign cand_ok = (random_x <= X_MAX) && (random_y <= Y_MAX);

    // Overlap of two GRID-sized squares: both corner distances below GRID.
    assign dx      = $signed({1'b0, cand_x}) - $signed({1'b0, body_x});
    assign dy      = $signed({2'b00, cand_y}) - $signed({2'b00, body_y});
    assign x_near  = (dx < GRID_S) && (dx > NEG_GRID);
    assign y_near  = (dy < GRID_S) && (dy > NEG_GRID);
    assign overlap = x_near && y_near;

    // Placement sequencer; every output is registered here.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cand_x      <= '0;
            cand_y      <= '0;
            cmp_idx     <= '0;
            scan_last   <= '0;
            body_addr   <= '0;
            apple_x     <= '0;
            apple_y     <= '0;
            apple_valid <= 1'b0;
            busy        <= 1'b0;
        end else if (!start) begin
            // Game stopped: drop everything in flight, keep the last coordinates.
            state       <= ST_IDLE;
            cmp_idx     <= '0;
            body_addr   <= '0;
            apple_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!apple_valid) begin
                        state <= ST_SAMPLE;
                        busy  <= 1'b1;
                    end else if (eat) begin
                        apple_valid <= 1'b0;
                        state       <= ST_SAMPLE;
                        busy        <= 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    // body_addr sits at 0 here, so segment 0 arrives on the
                    // first SCAN cycle and the scan has no dead cycle.
                    cand_x <= random_x;
                    cand_y <= random_y;
                    if (cand_ok) begin
                        if (snake_len == '0) begin
                            state <= ST_PLACE;
                            busy  <= 1'b0;
                        end else begin
                            state     <= ST_SCAN;
                            scan_last <= LEN_W'(snake_len - 1'b1);
                            cmp_idx   <= '0;
                            body_addr <= LEN_W'(snake_len > (LEN_W+1)'(1));
                        end
                    end
                end

                ST_SCAN: begin
                    if (overlap) begin
                        state     <= ST_SAMPLE;
                        cmp_idx   <= '0;
                        body_addr <= '0;
                    end else if (cmp_idx == scan_last) begin
                        state     <= ST_PLACE;
                        busy      <= 1'b0;
                        cmp_idx   <= '0;
                        body_addr <= '0;
                    end else begin
                        cmp_idx <= cmp_idx + LEN_W'(1);
                        // Issue runs one index ahead of compare; stop at the last one.
                        if (body_addr != scan_last) begin
                            body_addr <= body_addr + LEN_W'(1);
                        end
                    end
                end

                ST_PLACE: begin
                    apple_x     <= cand_x;
                    apple_y     <= cand_y;
                    apple_valid <= 1'b1;
                    state       <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef APPLE_SCORE_EN
    logic start_d;

    // Eaten-apple counter: clears on a game start edge, saturates at 255.
    always_ff @(posedge VGA_clk or negedge rst_n) begin
        if (!rst_n) begin
            score   <= '0;
            start_d <= 1'b0;
        end else begin
            start_d <= start;
            if (start && !start_d) begin
                score <= '0;
            end else if (start && (state == ST_IDLE) && apple_valid && eat &&
                         (score != 8'hFF)) begin
                score <= score + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_apple_placement_ctrl.sv
// Bench for apple_placement_ctrl: table of placement scenarios plus hand-written
// abort / reset sequences. Expected placements go into a scoreboard queue when a
// scenario is launched and are checked when apple_valid rises.
`timescale 1ns/1ps

module tb_apple_placement_ctrl;

    localparam int LEN_W = 5;

    logic             VGA_clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             eat;
    logic [9:0]       random_x;
    logic [8:0]       random_y;
    logic [LEN_W:0]   snake_len;
    logic [LEN_W-1:0] body_addr;
    logic [9:0]       body_x;
    logic [8:0]       body_y;
    logic [9:0]       apple_x;
    logic [8:0]       apple_y;
    logic             apple_valid;
    logic             busy;
`ifdef APPLE_SCORE_EN
    logic [7:0]       score;
`endif

    always #5 VGA_clk = ~VGA_clk;

    apple_placement_ctrl #(
        .GRID(10), .SCREEN_W(640), .SCREEN_H(480), .LEN_W(LEN_W)
    ) dut (
        .VGA_clk(VGA_clk),
        .rst_n(rst_n),
        .start(start),
        .eat(eat),
        .random_x(random_x),
        .random_y(random_y),
        .snake_len(snake_len),
        .body_addr(body_addr),
        .body_x(body_x),
        .body_y(body_y),
        .apple_x(apple_x),
        .apple_y(apple_y),
        .apple_valid(apple_valid),
        .busy(busy)
`ifdef APPLE_SCORE_EN
        ,
        .score(score)
`endif
    );

    // Body store: segment i at (100+10i, 50), registered read.
    logic [9:0] seg_x [0:31];
    logic [8:0] seg_y [0:31];
    always @(posedge VGA_clk) begin
        body_x <= seg_x[body_addr];
        body_y <= seg_y[body_addr];
    end

    typedef struct {
        int len;
        int c1x; int c1y; int rep;   // value on random_* at edges 1..rep
        int c2e; int c2x; int c2y;   // value at edge c2e (0 = none)
        int lat;                     // edges from SAMPLE entry to apple_valid
        int ex;  int ey;             // expected placement
        int mid_eat;                 // eat high before this edge (0 = none)
    } vec_t;

    typedef struct {
        int x; int y; int lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    vec_t rvec;

    int checks    = 0;
    int failures  = 0;
    int edge_cnt  = 0;
    int start_cnt = 0;
    int exp_score = 0;
    int prev_x    = 0;
    int prev_y    = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int vx(input vec_t v, input int j);
        if (j >= 1 && j <= v.rep) return v.c1x;
        if (v.c2e != 0 && j == v.c2e) return v.c2x;
        return 1023;
    endfunction

    function automatic int vy(input vec_t v, input int j);
        if (j >= 1 && j <= v.rep) return v.c1y;
        if (v.c2e != 0 && j == v.c2e) return v.c2y;
        return 511;
    endfunction

    always @(posedge VGA_clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard consumer: one expected entry per rising apple_valid.
    always @(negedge VGA_clk) begin
        if (rst_n === 1'b1 && apple_valid === 1'b1 && prev_valid == 1'b0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_place", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("apple_x", int'(apple_x), e.x);
                chk("apple_y", int'(apple_y), e.y);
                chk("latency", edge_cnt - start_cnt - 1, e.lat);
            end
        end
        prev_valid = (apple_valid === 1'b1);
    end

    // Launch one placement (by start rise or eat pulse) and wait for it.
    task automatic run_vec(input vec_t v, input bit use_start);
        exp_t e;
        @(negedge VGA_clk);
        snake_len = (LEN_W+1)'(v.len);
        random_x  = 10'd1023;
        random_y  = 9'd511;
        if (use_start) begin
            start     = 1'b1;
            exp_score = 0;
        end else begin
            eat       = 1'b1;
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
        end
        e.x = v.ex; e.y = v.ey; e.lat = v.lat;
        sb_q.push_back(e);
        start_cnt = edge_cnt;
        for (int k = 0; k < 64; k++) begin
            @(negedge VGA_clk);
            eat = (v.mid_eat != 0 && k + 1 == v.mid_eat);
            if (k == 0) begin
                chk("busy_enter", int'(busy), 1);
                chk("valid_clear", int'(apple_valid), 0);
                chk("apple_x_hold", int'(apple_x), prev_x);
                chk("apple_y_hold", int'(apple_y), prev_y);
            end
            if (k == 1 && v.len >= 2) chk("body_addr_1", int'(body_addr), 1);
            if (k == 1 && v.lat == 2) chk("busy_one_cycle", int'(busy), 0);
            random_x = 10'(vx(v, k + 1));
            random_y = 9'(vy(v, k + 1));
            if (sb_q.size() == 0) break;
        end
        eat = 1'b0;
        if (sb_q.size() != 0) begin
            chk("place_timeout", 0, 1);
            sb_q.delete();
        end
        chk("busy_done", int'(busy), 0);
        prev_x = v.ex;
        prev_y = v.ey;
        $display("txn len=%0d place=(%0d,%0d) lat=%0d score_model=%0d",
                 v.len, v.ex, v.ey, v.lat, exp_score);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           len c1x  c1y  rep c2e c2x  c2y  lat ex   ey   mid_eat
        vecs[0] = '{0, 100,  50, 1, 0,   0,   0,  2, 100,  50, 0};
        vecs[1] = '{0, 635,  40, 3, 4, 200,  40,  5, 200,  40, 0};
        vecs[2] = '{3, 105,  55, 1, 3, 300, 300,  7, 300, 300, 0};
        vecs[3] = '{1, 110,  60, 1, 0,   0,   0,  3, 110,  60, 0};
        vecs[4] = '{0, 630, 470, 1, 0,   0,   0,  2, 630, 470, 0};
        vecs[5] = '{0, 631,   0, 2, 3,   0,   0,  4,   0,   0, 0};
        vecs[6] = '{0,   0, 471, 1, 2, 630,   0,  3, 630,   0, 0};
        vecs[7] = '{5, 145,  45, 1, 7, 400, 200, 13, 400, 200, 0};
        vecs[8] = '{3,  91,  41, 1, 3, 500, 400,  7, 500, 400, 0};
        vecs[9] = '{2,  90,  40, 1, 0,   0,   0,  4,  90,  40, 0};
        rvec    = '{3, 500, 100, 1, 0,   0,   0,  5, 500, 100, 2};

        for (int i = 0; i < 32; i++) begin
            seg_x[i] = 10'(100 + 10 * i);
            seg_y[i] = 9'd50;
        end

        rst_n = 1'b0; start = 1'b0; eat = 1'b0;
        random_x = '0; random_y = '0; snake_len = '0;
        repeat (3) @(negedge VGA_clk);
        chk("rst_apple_x", int'(apple_x), 0);
        chk("rst_apple_y", int'(apple_y), 0);
        chk("rst_valid", int'(apple_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_body_addr", int'(body_addr), 0);
`ifdef APPLE_SCORE_EN
        chk("rst_score", int'(score), 0);
`endif
        rst_n = 1'b1;
        @(negedge VGA_clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i == 0);
`ifdef APPLE_SCORE_EN
        chk("score_after_table", int'(score), exp_score);
`endif

        // start dropped mid-scan with body_addr at 2
        @(negedge VGA_clk);
        snake_len = 6'd5; eat = 1'b1;
        random_x = 10'd1023; random_y = 9'd511;
        exp_score = exp_score + 1;
        @(negedge VGA_clk);
        eat = 1'b0;
        chk("abort_busy", int'(busy), 1);
        random_x = 10'd200; random_y = 9'd300;
        @(negedge VGA_clk);
        chk("abort_addr1", int'(body_addr), 1);
        random_x = 10'd1023; random_y = 9'd511;
        @(negedge VGA_clk);
        chk("abort_addr2", int'(body_addr), 2);
        start = 1'b0;
        @(negedge VGA_clk);
        chk("abort_valid", int'(apple_valid), 0);
        chk("abort_busy0", int'(busy), 0);
        chk("abort_addr0", int'(body_addr), 0);
        chk("abort_x_hold", int'(apple_x), prev_x);
        chk("abort_y_hold", int'(apple_y), prev_y);
`ifdef APPLE_SCORE_EN
        chk("score_abort", int'(score), exp_score);
`endif
        @(negedge VGA_clk);
        chk("idle_valid", int'(apple_valid), 0);
        $display("txn abort mid-scan");

        // fresh placement after re-raising start; eat during SCAN is ignored
        run_vec(rvec, 1'b1);
`ifdef APPLE_SCORE_EN
        chk("score_restart", int'(score), exp_score);
`endif

        // start falling together with eat: start wins
        @(negedge VGA_clk);
        start = 1'b0; eat = 1'b1;
        @(negedge VGA_clk);
        eat = 1'b0;
        chk("start_prio_valid", int'(apple_valid), 0);
        chk("start_prio_busy", int'(busy), 0);
`ifdef APPLE_SCORE_EN
        chk("start_prio_score", int'(score), exp_score);
`endif
        $display("txn start/eat same cycle");

        // asynchronous reset during a scan
        @(negedge VGA_clk);
        start = 1'b1; snake_len = 6'd5;
        random_x = 10'd1023; random_y = 9'd511;
        @(negedge VGA_clk);
        random_x = 10'd200; random_y = 9'd300;
        @(negedge VGA_clk);
        random_x = 10'd1023; random_y = 9'd511;
        @(negedge VGA_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_apple_x", int'(apple_x), 0);
        chk("arst_apple_y", int'(apple_y), 0);
        chk("arst_valid", int'(apple_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_body_addr", int'(body_addr), 0);
        start = 1'b0;
        @(negedge VGA_clk);
        rst_n = 1'b1;
        @(negedge VGA_clk);
        $display("txn async reset mid-scan");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apple_placement_ctrl.md
Name: apple_placement_ctrl

Overview:
- Sequences apple placement for the snake game in the VGA_clk domain.
- On game start, and each time the apple is eaten, it samples the free-running random coordinate generator and bounds-checks the candidate.
- It then scans the snake body store to reject any candidate that overlaps a body segment.
- It publishes a stable apple_x/apple_y/apple_valid to the apple-drawing logic.

Parameters:
- GRID, 10, apple and segment square size in pixels.
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- LEN_W, 5, body address width; max snake length is 2^LEN_W.

Ports:
- VGA_clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; game running.
- eat  in  1  one-cycle pulse; head hit the apple.
- random_x  in  10  random x from the generator; changes every cycle.
- random_y  in  9  random y from the generator.
- snake_len  in  LEN_W+1  number of live segments, 0..2^LEN_W.
- body_addr  out  LEN_W  segment index to the body store.
- body_x  in  10  segment x; valid 1 cycle after body_addr.
- body_y  in  9  segment y; valid 1 cycle after body_addr.
- apple_x  out  10  placed apple x, top-left corner.
- apple_y  out  9  placed apple y, top-left corner.
- apple_valid  out  1  apple currently on screen.
- busy  out  1  placement in progress.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; apple_x=0, apple_y=0, apple_valid=0, busy=0, body_addr=0. Internal candidate and counters are cleared.
- All outputs are registered on posedge VGA_clk.
- IDLE:
  - start=1 and apple_valid=0 -> SAMPLE.
  - start=1, apple_valid=1 and eat=1 -> clear apple_valid next cycle, then SAMPLE.
- SAMPLE (busy=1):
  - Latch cand_x=random_x and cand_y=random_y.
  - Accept only if cand_x <= SCREEN_W-GRID and cand_y <= SCREEN_H-GRID. The comparisons are unsigned, at 10 and 9 bits respectively.
  - Rejected: stay in SAMPLE and re-sample next cycle.
  - Accepted and snake_len=0 -> PLACE.
  - Accepted and snake_len>0 -> SCAN with body_addr=0.
- SCAN (busy=1): one address per cycle, pipelined.
  - body_addr increments 0..snake_len-1.
  - The compare for address k happens in the cycle after it is issued.
  - Overlap test: |cand_x-body_x| < GRID AND |cand_y-body_y| < GRID, computed with 11-bit signed differences.
  - Any overlap -> abort the scan and return to SAMPLE. body_addr returns to 0.
  - Compare of index snake_len-1 passes -> PLACE.
  - snake_len is sampled on SCAN entry; later changes are ignored until the next SAMPLE.
- PLACE (1 cycle): apple_x<=cand_x, apple_y<=cand_y, apple_valid<=1, busy<=0 -> IDLE.
- Placement latency: cycles from entering SAMPLE until apple_valid rises.
  - No rejection: 1 + snake_len + 1 (snake_len>0), or 2 (snake_len=0).
  - Each rejection adds cycles; the retry count is unbounded.
- apple_x/apple_y hold the previous placement while a new one runs; consumers gate on apple_valid.
- eat outside IDLE-with-apple_valid is ignored.
- If eat and start fall in the same cycle, start has priority.
- start=0 in any state -> IDLE next cycle with apple_valid=0, busy=0, body_addr=0. This is a synchronous abort; apple_x/apple_y are held.
- rst_n asserted mid-SCAN -> immediate reset values; no partial placement is published.

Optional Feature:
- Macro: APPLE_SCORE_EN.
- Defined: adds output score (8 bits), reset 0.
  - Increments (saturating at 255) on each eat pulse accepted in IDLE with apple_valid=1.
  - Clears when start goes 0->1.
- Undefined: no score port or logic; behaviour otherwise identical.

Test Plan:
- Reset then start=1, snake_len=0, random_x=100, random_y=50 -> apple_valid=1 with apple_x=100, apple_y=50 exactly 2 cycles after start; busy high for 1 cycle.
- random_x=635 for 3 cycles, then 200; random_y=40; snake_len=0 -> rejected 3 times; apple_x=200, apple_y=40, apple_valid after 5 cycles.
- snake_len=3, body=(100,50),(110,50),(120,50); candidate (105,55) -> overlap on index 0, back to SAMPLE; next candidate (300,300) -> placed after 1+3+1 cycles; body_addr sequence 0,1,2.
- Apple placed at (300,300); pulse eat=1 -> apple_valid 0 next cycle, busy 1, apple_x holds 300 until the new PLACE.
- start=0 mid-SCAN at body_addr=2 -> next cycle IDLE, apple_valid=0, busy=0. Re-raise start -> a fresh placement starts from SAMPLE.
- With APPLE_SCORE_EN: 3 eat pulses in IDLE with apple_valid=1 -> score=3. Eat pulse during SCAN -> score unchanged. start toggle 0->1 -> score=0.
